regfile_wb_scheduler: RTL and testbench

//   Owns the single write port of the 32x32 register file and shares it between
//   N_REQ writeback requesters (ALU, load unit, ...) via round-robin arbitration.

---
 rtl/regfile_wb_scheduler.sv | 96 +++++++++
 tb/tb_regfile_wb_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Writeback port scheduler for the 32x32 register file.
// Round-robin shares the single write port among N_REQ writeback sources,
// registers the winning write for one cycle, and keeps a pending-write
// scoreboard so decode can detect reads of uncommitted destinations.
module regfile_wb_scheduler #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic                      rsv_ready,
  input  logic [ADDR_W-1:0]         rd_addr0,
  input  logic [ADDR_W-1:0]         rd_addr1,
  output logic                      hazard0,
  output logic                      hazard1,
  output logic                      rf_wr_ena,
  output logic [ADDR_W-1:0]         rf_wr_addr,
  output logic [DATA_W-1:0]         rf_wr_data,
  output logic [31:0]               pending
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_nxt;
  logic              found;
  int unsigned       gidx;
  int unsigned       idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [31:0]       pend_nxt;
  logic              rsv_take;

  // Round-robin search starting at ptr; selects the granted requester's payload.
  always_comb begin
    found    = 1'b0;
    gidx     = 0;
    idx      = 0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        gidx     = idx;
        sel_addr = req_addr[idx*ADDR_W +: ADDR_W];
        sel_data = req_data[idx*DATA_W +: DATA_W];
      end
    end
    req_ready = '0;
    if (found) req_ready[gidx] = 1'b1;
    ptr_nxt = PTR_W'((gidx + 1) % N_REQ);
  end

  // Reservation acceptance, read hazards and next scoreboard value.
  always_comb begin
    rsv_ready = !pending[rsv_addr] || (rsv_addr == '0);
    rsv_take  = rsv_valid && rsv_ready && (rsv_addr != '0);
    hazard0   = pending[rd_addr0] && (rd_addr0 != '0);
    hazard1   = pending[rd_addr1] && (rd_addr1 != '0);
    pend_nxt  = pending;
    // clear first so a same-edge reservation of the committing register wins
    if (rf_wr_ena) pend_nxt[rf_wr_addr] = 1'b0;
    if (rsv_take)  pend_nxt[rsv_addr]   = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Registered write port, arbitration pointer and scoreboard state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      rf_wr_ena  <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      pending    <= '0;
    end else begin
      pending <= pend_nxt;
      if (found) begin
        ptr        <= ptr_nxt;
        rf_wr_addr <= sel_addr;
        rf_wr_data <= sel_data;
        rf_wr_ena  <= (sel_addr != '0);
      end else begin
        rf_wr_ena  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus constrained-random
// traffic compared every cycle against a behavioural model of the scheduler.
module tb_regfile_wb_scheduler;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            rsv_valid;
  logic [AW-1:0]   rsv_addr;
  logic            rsv_ready;
  logic [AW-1:0]   rd_addr0, rd_addr1;
  logic            hazard0, hazard1;
  logic            rf_wr_ena;
  logic [AW-1:0]   rf_wr_addr;
  logic [DW-1:0]   rf_wr_data;
  logic [31:0]     pending;

  regfile_wb_scheduler #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .hazard0(hazard0), .hazard1(hazard1),
    .rf_wr_ena(rf_wr_ena), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int          m_ptr;
  bit [31:0]   m_pend;
  bit          m_wena;
  bit [AW-1:0] m_waddr;
  bit [DW-1:0] m_wdata;
  int          g_last = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_pend = '0; m_wena = 0; m_waddr = '0; m_wdata = '0; g_last = -1;
  endtask

  // Compare all outputs against the model, then advance model and DUT one edge.
  task automatic step();
    int g;
    logic [N-1:0] er;
    bit rsv_ok;
    bit [31:0] np;
    #1;
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    rsv_ok = (m_pend[rsv_addr] == 1'b0) || (rsv_addr == 0);
    check("req_ready",  req_ready,  er);
    check("rsv_ready",  rsv_ready,  rsv_ok);
    check("hazard0",    hazard0,    m_pend[rd_addr0] && rd_addr0 != 0);
    check("hazard1",    hazard1,    m_pend[rd_addr1] && rd_addr1 != 0);
    check("rf_wr_ena",  rf_wr_ena,  m_wena);
    check("rf_wr_addr", rf_wr_addr, m_waddr);
    check("rf_wr_data", rf_wr_data, m_wdata);
    check("pending",    pending,    m_pend);
    g_last = g;
    np = m_pend;
    if (m_wena) np[m_waddr] = 1'b0;
    if (rsv_valid && rsv_ok && rsv_addr != 0) np[rsv_addr] = 1'b1;
    m_pend = np;
    if (g >= 0) begin
      m_ptr   = (g + 1) % N;
      m_waddr = req_addr[g*AW +: AW];
      m_wdata = req_data[g*DW +: DW];
      m_wena  = (m_waddr != 0);
    end else begin
      m_wena = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_addr = '0; req_data = '0;
    rsv_valid = 0; rsv_addr = '0; rd_addr0 = '0; rd_addr1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    model_reset();
    #12;
    check("reset_ena",     rf_wr_ena,  1'b0);
    check("reset_addr",    rf_wr_addr, 5'd0);
    check("reset_data",    rf_wr_data, 32'd0);
    check("reset_pending", pending,    32'd0);
    @(negedge clk);
    rst = 1;

    // 1: single write through requester 0
    req_valid = 2'b01; req_addr[0 +: AW] = 5'd5; req_data[0 +: DW] = 32'hDEADBEEF;
    #1 check("t1_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    #1;
    check("t1_ena",  rf_wr_ena,  1'b1);
    check("t1_addr", rf_wr_addr, 5'd5);
    check("t1_data", rf_wr_data, 32'hDEADBEEF);
    step();
    check("t1_ena_off", rf_wr_ena, 1'b0);

    // 2: both requesters continuously valid from ptr=0 alternate grants
    do_reset();
    req_valid = 2'b11;
    req_addr  = {5'd4, 5'd3};
    req_data  = {32'h4444, 32'h3333};
    for (int c = 0; c < 4; c++) begin
      #1 check("t2_grant", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      if (c > 0) check("t2_ena", rf_wr_ena, 1'b1);
      step();
    end
    req_valid = '0;
    step();

    // 3: reservation raises hazard until the commit edge has passed
    rsv_valid = 1; rsv_addr = 5'd7; rd_addr0 = 5'd7;
    step();
    rsv_valid = 0;
    #1;
    check("t3_hazard_set", hazard0, 1'b1);
    check("t3_pend_set",   pending[7], 1'b1);
    req_valid = 2'b01; req_addr[0 +: AW] = 5'd7; req_data[0 +: DW] = 32'h77;
    step();
    req_valid = '0;
    #1;
    check("t3_commit_ena",   rf_wr_ena, 1'b1);
    check("t3_hazard_still", hazard0,   1'b1);
    step();
    check("t3_hazard_clr", hazard0,    1'b0);
    check("t3_pend_clr",   pending[7], 1'b0);

    // 4: writes and reservations of x0 are accepted and dropped
    req_valid = 2'b01; req_addr[0 +: AW] = 5'd0; req_data[0 +: DW] = 32'h1234;
    #1 check("t4_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    rsv_valid = 1; rsv_addr = 5'd0;
    #1;
    check("t4_ena",       rf_wr_ena, 1'b0);
    check("t4_rsv_ready", rsv_ready, 1'b1);
    step();
    rsv_valid = 0;
    check("t4_pending", pending, 32'd0);

    // 5: unreserved commit to x9 coinciding with a reservation of x9
    req_valid = 2'b01; req_addr[0 +: AW] = 5'd9; req_data[0 +: DW] = 32'h99;
    step();
    req_valid = '0;
    rsv_valid = 1; rsv_addr = 5'd9;
    #1 check("t5_commit", rf_wr_ena, 1'b1);
    step();
    check("t5_set_wins", pending[9], 1'b1);
    check("t5_rsv_stall", rsv_ready, 1'b0);
    step();
    rsv_valid = 0;

    // 6: asynchronous reset while a write is in flight and pending is nonzero
    rsv_valid = 1; rsv_addr = 5'd12; rd_addr1 = 5'd12;
    step();
    rsv_valid = 0;
    req_valid = 2'b10; req_addr[AW +: AW] = 5'd3; req_data[DW +: DW] = 32'hABCD;
    step();
    req_valid = '0;
    #1 check("t6_pre_ena", rf_wr_ena, 1'b1);
    #1 rst = 0;
    #1;
    check("t6_ena",     rf_wr_ena,  1'b0);
    check("t6_addr",    rf_wr_addr, 5'd0);
    check("t6_data",    rf_wr_data, 32'd0);
    check("t6_pending", pending,    32'd0);
    check("t6_hazard1", hazard1,    1'b0);
    model_reset();
    @(negedge clk);
    rst = 1;
    req_valid = 2'b11;
    #1 check("t6_first_grant", req_ready, 2'b01);
    step();

    // random traffic: requesters hold payload while waiting for a grant
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && g_last != i && c > 0)) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
          req_data[i*DW +: DW] = $urandom;
        end
      end
      rsv_valid = ($urandom_range(0, 1) == 1);
      rsv_addr  = AW'($urandom_range(0, 7));
      rd_addr0  = AW'($urandom_range(0, 7));
      rd_addr1  = AW'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
